// File: rtl/fb_write_master_if.sv
// Avalon-MM write bus between the frame buffer write master and the SDRAM port.
interface fb_write_master_if;
  logic [25:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  modport master (
    output master_address,
    output master_write,
    output master_writedata,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_writedata,
    output master_waitrequest
  );
endinterface

// File: rtl/fb_write_master.sv
// Frame buffer write master: queues rasterizer pixels and writes them to SDRAM
// over Avalon-MM, and can fill the whole frame with one colour on request.
module fb_write_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int PIX_STRIDE = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [25:0]               base,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [9:0]                pix_x,
  input  logic [8:0]                pix_y,
  input  logic [31:0]               pix_color,
  input  logic                      clear_start,
  input  logic [31:0]               clear_color,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [15:0]               drop_count,
  fb_write_master_if.master         av
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_N = H_RES * V_RES;
  localparam int FILL_W = $clog2(FILL_N);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_N - 1);
  localparam logic [9:0]  X_LIM  = 10'(H_RES);
  localparam logic [8:0]  Y_LIM  = 9'(V_RES);
  localparam logic [25:0] STRIDE = 26'(PIX_STRIDE);

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

  typedef struct packed {
    logic [25:0] addr;
    logic [31:0] data;
  } wr_t;

  state_t              state_q, state_d;
  wr_t                 fifo_mem [FIFO_DEPTH];
  wr_t                 fifo_head;
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full;
  logic                accept, in_range, push, pop;
  logic [18:0]         pix_index;
  logic [25:0]         pix_addr;
  logic                wr_q;
  logic [25:0]         addr_q;
  logic [31:0]         data_q;
  logic                wr_done, slot_free;
  logic [FILL_W-1:0]   fill_cnt, fill_next;
  logic [25:0]         fill_base, fill_addr;
  logic [31:0]         fill_color;
  logic                fill_last_done;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  assign accept    = pix_valid && pix_ready;
  assign in_range  = (pix_x < X_LIM) && (pix_y < Y_LIM);
  assign push      = accept && in_range;
  assign pix_index = 19'(pix_y) * 19'(H_RES) + 19'(pix_x);
  assign pix_addr  = base + 26'(pix_index) * STRIDE;

  // A write retires on any edge it is presented without stall; the output
  // slot may be reloaded on that same edge for back-to-back writes.
  assign wr_done   = wr_q && !av.master_waitrequest;
  assign slot_free = !wr_q || wr_done;
  assign pop       = (state_q != FILL) && !fifo_empty && slot_free;

  assign fill_next      = wr_done ? fill_cnt + 1'b1 : fill_cnt;
  assign fill_addr      = fill_base + 26'(fill_next) * STRIDE;
  assign fill_last_done = (state_q == FILL) && wr_done && (fill_cnt == FILL_LAST);

  assign av.master_address   = addr_q;
  assign av.master_write     = wr_q;
  assign av.master_writedata = data_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: drain queued pixels before filling, fill until the last slot retires.
  // NOTE: state_d is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_start) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !wr_q) state_d = FILL;
      FILL:    if (fill_last_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state and FIFO level only.
  always_comb begin
    pix_ready  = 1'b0;
    clear_busy = 1'b0;
    if (state_q == IDLE) pix_ready = !fifo_full;
    else                 clear_busy = 1'b1;
  end

  // Pixel queue storage.
  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{addr: pix_addr, data: pix_color};
  end

  // Pixel queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Avalon output slot: holds address/data under stall, reloads from the queue or fill generator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (state_q == FILL) begin
      if (fill_last_done) begin
        wr_q <= 1'b0;
      end else if (slot_free) begin
        wr_q   <= 1'b1;
        addr_q <= fill_addr;
        data_q <= fill_color;
      end
    end else if (pop) begin
      wr_q   <= 1'b1;
      addr_q <= fifo_head.addr;
      data_q <= fifo_head.data;
    end else if (wr_done) begin
      wr_q <= 1'b0;
    end
  end

  // Clear command: latch base/colour at start, count retired fill writes, pulse done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt   <= '0;
      fill_base  <= '0;
      fill_color <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= fill_last_done;
      if (state_q == IDLE && clear_start) begin
        fill_base  <= base;
        fill_color <= clear_color;
      end
      if (state_q == DRAIN)                              fill_cnt <= '0;
      else if (state_q == FILL && wr_done && !fill_last_done) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Saturating count of accepted pixels that fall outside the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          drop_count <= '0;
    else if (accept && !in_range && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
  end

endmodule

// File: tb/tb_fb_write_master.sv
// Self-checking bench for fb_write_master: table-driven pixel vectors plus
// hand-written backpressure, saturation, clear and reset sequences. Expected
// writes go into a queue at acceptance and are compared as writes retire.
module tb_fb_write_master;

  localparam int H      = 640;
  localparam int V      = 4;     // short frame keeps the full clear sequence affordable
  localparam int STRIDE = 8;
  localparam int FILL_N = H * V;

  typedef struct packed {
    logic [25:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [25:0] b;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [31:0] c;
    logic        wr;
    logic [25:0] ea;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] base;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [31:0] pix_color;
  logic        clear_start;
  logic [31:0] clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic [15:0] drop_count;

  fb_write_master_if av_if ();

  fb_write_master #(.FIFO_DEPTH(8), .H_RES(H), .V_RES(V), .PIX_STRIDE(STRIDE)) dut (
    .clk         (clk),
    .reset       (reset),
    .base        (base),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .drop_count  (drop_count),
    .av          (av_if)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_wr   = 0;
  int          n_done = 0;
  logic [15:0] exp_drop = '0;
  wr_t         exp_q[$];
  vec_t        vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] exp_addr(input logic [25:0] b, input int x, input int y);
    return b + 26'((y * H + x) * STRIDE);
  endfunction

  // Monitor: scoreboard on retired writes, Avalon hold rule, no acceptance while clearing.
  logic        prev_pend = 1'b0;
  logic [25:0] prev_addr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (!reset) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("hold_write", 64'(av_if.master_write), 64'd1);
        check("hold_addr",  64'(av_if.master_address), 64'(prev_addr));
        check("hold_data",  64'(av_if.master_writedata), 64'(prev_data));
      end
      if (av_if.master_write && !av_if.master_waitrequest) begin
        wr_t e;
        n_wr++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(av_if.master_address), 64'h3FFFFFFFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(av_if.master_address), 64'(e.addr));
          check("wr_data", 64'(av_if.master_writedata), 64'(e.data));
        end
      end
      if (clear_busy) check("ready_while_busy", 64'(pix_ready), 64'd0);
      if (clear_done) n_done++;
      prev_pend = av_if.master_write && av_if.master_waitrequest;
      prev_addr = av_if.master_address;
      prev_data = av_if.master_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel until accepted or max_wait cycles pass; expectation recorded on acceptance.
  task automatic send(input logic [25:0] b, input logic [9:0] x, input logic [8:0] y,
                      input logic [31:0] c, input logic exp_wr, input logic [25:0] ea,
                      input int max_wait, output logic ok);
    wr_t w;
    base = b; pix_x = x; pix_y = y; pix_color = c; pix_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < max_wait && !ok; k++) begin
      @(negedge clk);
      if (pix_ready) begin
        ok = 1'b1;
        if (exp_wr) begin
          w.addr = ea; w.data = c;
          exp_q.push_back(w);
        end else if (exp_drop != 16'hFFFF) begin
          exp_drop++;
        end
      end
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_wait);
    logic ok = 1'b0;
    for (int k = 0; k < max_wait && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !av_if.master_write) ok = 1'b1;
    end
    tick();
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic push_fill(input logic [25:0] b, input logic [31:0] c);
    wr_t w;
    for (int i = 0; i < FILL_N; i++) begin
      w.addr = b + 26'(i * STRIDE);
      w.data = c;
      exp_q.push_back(w);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   wr0, done0, hi, first_block, cnt;

    vt[0] = '{b: 26'h0000000, x: 10'd0,   y: 9'd0,   c: 32'h000000AA, wr: 1'b1, ea: 26'h0000000};
    vt[1] = '{b: 26'h0000000, x: 10'd639, y: 9'd3,   c: 32'h00ABCDEF, wr: 1'b1, ea: 26'h0004FF8};
    vt[2] = '{b: 26'h3FFFFFF, x: 10'd1,   y: 9'd0,   c: 32'h00010203, wr: 1'b1, ea: 26'h0000007};
    vt[3] = '{b: 26'h0123456, x: 10'd100, y: 9'd1,   c: 32'h00FF0000, wr: 1'b1, ea: 26'h0124B76};
    vt[4] = '{b: 26'h0000000, x: 10'd640, y: 9'd0,   c: 32'h00111111, wr: 1'b0, ea: 26'h0};
    vt[5] = '{b: 26'h0000000, x: 10'd0,   y: 9'd480, c: 32'h00222222, wr: 1'b0, ea: 26'h0};
    vt[6] = '{b: 26'h0000000, x: 10'd0,   y: 9'd4,   c: 32'h00333333, wr: 1'b0, ea: 26'h0};
    vt[7] = '{b: 26'h0100000, x: 10'd3,   y: 9'd2,   c: 32'h00445566, wr: 1'b1, ea: 26'h0102818};

    reset = 1'b0; base = '0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clear_start = 1'b0; clear_color = '0; av_if.master_waitrequest = 1'b0;

    // Reset state.
    #3;
    check("rst_write", 64'(av_if.master_write), 64'd0);
    check("rst_addr",  64'(av_if.master_address), 64'd0);
    check("rst_data",  64'(av_if.master_writedata), 64'd0);
    check("rst_busy",  64'(clear_busy), 64'd0);
    check("rst_done",  64'(clear_done), 64'd0);
    check("rst_drop",  64'(drop_count), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single pixel, no stall: write appears after the edge following acceptance, for one cycle.
    base = 26'h0100000; pix_x = 10'd3; pix_y = 9'd2; pix_color = 32'h00112233; pix_valid = 1'b1;
    @(negedge clk);
    check("t1_ready", 64'(pix_ready), 64'd1);
    exp_q.push_back('{addr: exp_addr(26'h0100000, 3, 2), data: 32'h00112233});
    tick();
    pix_valid = 1'b0;
    @(negedge clk);
    check("t1_lat_n0", 64'(av_if.master_write), 64'd0);
    @(negedge clk);
    check("t1_lat_n1", 64'(av_if.master_write), 64'd1);
    check("t1_addr",   64'(av_if.master_address), 64'h0102818);
    check("t1_data",   64'(av_if.master_writedata), 64'h00112233);
    @(negedge clk);
    check("t1_one_cycle", 64'(av_if.master_write), 64'd0);
    tick();

    // Same pixel with waitrequest held for 5 cycles.
    wr0 = n_wr;
    av_if.master_waitrequest = 1'b1;
    send(26'h0100000, 10'd3, 9'd2, 32'h00112233, 1'b1, exp_addr(26'h0100000, 3, 2), 20, ok);
    check("t2_accept", 64'(ok), 64'd1);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (av_if.master_write) hi++;
      else if (hi > 0) break;
      tick();
      if (hi == 5) av_if.master_waitrequest = 1'b0;
    end
    tick();
    av_if.master_waitrequest = 1'b0;
    check("t2_high_cycles", 64'(hi), 64'd6);
    check("t2_completions", 64'(n_wr - wr0), 64'd1);

    // Table-driven vectors: address arithmetic, truncation, out-of-range drops.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].b, vt[i].x, vt[i].y, vt[i].c, vt[i].wr, vt[i].ea, 20, ok);
      check($sformatf("vec%0d_accept", i), 64'(ok), 64'd1);
      wait_idle($sformatf("vec%0d_idle", i), 50);
    end
    check("vec_drop_count", 64'(drop_count), 64'(exp_drop));

    // Backpressure: 8 queued plus 1 in flight, then release and finish the stream.
    wr0 = n_wr;
    first_block = -1;
    av_if.master_waitrequest = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(26'h40, 10'(i * 7), 9'(i % 4), 32'h00A00000 | 32'(i), 1'b1,
           exp_addr(26'h40, i * 7, i % 4), 20, ok);
      if (!ok) begin
        if (first_block < 0) first_block = i;
        av_if.master_waitrequest = 1'b0;
        send(26'h40, 10'(i * 7), 9'(i % 4), 32'h00A00000 | 32'(i), 1'b1,
             exp_addr(26'h40, i * 7, i % 4), 50, ok);
        check("bp_retry_accept", 64'(ok), 64'd1);
      end
    end
    av_if.master_waitrequest = 1'b0;
    check("bp_first_block", 64'(first_block), 64'd9);
    wait_idle("bp_idle", 100);
    check("bp_completions", 64'(n_wr - wr0), 64'd12);

    // Drop counter saturation.
    base = '0; pix_x = 10'd640; pix_y = 9'd0; pix_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 70000 && cnt < 65537; k++) begin
      @(negedge clk);
      if (pix_ready) begin
        cnt++;
        if (exp_drop != 16'hFFFF) exp_drop++;
      end
      tick();
    end
    pix_valid = 1'b0;
    check("sat_drops_sent", 64'(cnt), 64'd65537);
    check("sat_drop_model", 64'(drop_count), 64'(exp_drop));
    check("sat_drop_max",   64'(drop_count), 64'hFFFF);

    // Clear with 3 pixels queued: pixels retire first, then every fill slot in order.
    wr0 = n_wr; done0 = n_done;
    av_if.master_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(26'h0, 10'(10 + i), 9'd1, 32'h00C00000 | 32'(i), 1'b1, exp_addr(26'h0, 10 + i, 1), 20, ok);
      check("clr_pix_accept", 64'(ok), 64'd1);
    end
    base = 26'h0; clear_color = 32'h00FF00FF; clear_start = 1'b1;
    @(negedge clk);
    push_fill(26'h0, 32'h00FF00FF);
    tick();
    clear_start = 1'b0; base = 26'h3ABCDE;
    @(negedge clk);
    check("clr_busy_rise", 64'(clear_busy), 64'd1);
    tick();
    for (int k = 0; k < 20000 && n_done == done0; k++) begin
      av_if.master_waitrequest = ($urandom_range(0, 3) == 0);
      if (k == 50) begin
        clear_start = 1'b1; clear_color = 32'hDEADBEEF;
      end else begin
        clear_start = 1'b0;
      end
      tick();
    end
    clear_start = 1'b0; av_if.master_waitrequest = 1'b0;
    repeat (3) tick();
    check("clr_done_pulses", 64'(n_done - done0), 64'd1);
    check("clr_writes",      64'(n_wr - wr0), 64'(3 + FILL_N));
    check("clr_queue_empty", 64'(exp_q.size()), 64'd0);
    check("clr_busy_fall",   64'(clear_busy), 64'd0);
    check("clr_ready_back",  64'(pix_ready), 64'd1);

    // Reset in the middle of a stalled fill.
    done0 = n_done;
    base = 26'h0200000; clear_color = 32'h00777777; clear_start = 1'b1;
    @(negedge clk);
    push_fill(26'h0200000, 32'h00777777);
    tick();
    clear_start = 1'b0;
    repeat (100) tick();
    av_if.master_waitrequest = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_write", 64'(av_if.master_write), 64'd0);
    check("mid_rst_busy",  64'(clear_busy), 64'd0);
    check("mid_rst_drop",  64'(drop_count), 64'd0);
    check("mid_rst_ready", 64'(pix_ready), 64'd1);
    tick();
    reset = 1'b1; av_if.master_waitrequest = 1'b0;
    exp_drop = '0;
    tick();
    wr0 = n_wr;
    send(26'h0200000, 10'd5, 9'd1, 32'h00123456, 1'b1, exp_addr(26'h0200000, 5, 1), 20, ok);
    check("post_rst_accept", 64'(ok), 64'd1);
    wait_idle("post_rst_idle", 50);
    check("post_rst_writes", 64'(n_wr - wr0), 64'd1);
    check("post_rst_no_done", 64'(n_done - done0), 64'd0);
    check("post_rst_drop", 64'(drop_count), 64'(exp_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
